lfsr_random_word_gen: RTL and testbench
=======================================

LFSR_RANDOM_WORD_GEN -- requirements
Module: lfsr_random_word_gen

Interface
REQ-001 Parameter LFSR_W, default 16: LFSR state width; legal range 4..32.
REQ-002 Parameter TAPS, default 16'hB400: Fibonacci feedback mask; bit i set means lfsr[i] enters the feedback XOR.
REQ-003 Parameter SEED_DEFAULT, default 16'h0001: value loaded at reset, on zero seed, and on lock-up recovery; SHALL be non-zero.
REQ-004 Parameter OUT_W, default 8: output word width; legal range 1..LFSR_W.
REQ-005 Parameter MIX_W, default 12: width of the external entropy input.
REQ-006 clk  in  1: single clock; all logic on its rising edge.
REQ-007 rst  in  1: reset, synchronous and active-high.
REQ-008 seed_load  in  1: one-cycle request to load seed.
REQ-009 seed  in  LFSR_W: seed value, sampled when seed_load=1.
REQ-010 mix_en  in  1: enables entropy mixing into feedback.
REQ-011 mix  in  MIX_W: entropy source, e.g. pixel position.
REQ-012 out_ready  in  1: consumer accepts word.
REQ-013 out_valid  out  1: out_data holds a complete word.
REQ-014 out_data  out  OUT_W: random word.
REQ-015 lockup  out  1: one-cycle pulse, all-zero LFSR recovered.

Function
REQ-016 Two states SHALL exist: FILL (generating bits) and PRESENT (word held, out_valid=1).
REQ-017 fb SHALL be XOR-reduce(lfsr AND TAPS), XORed with XOR-reduce(mix) when mix_en=1.
REQ-018 In FILL, each cycle: lfsr <= {lfsr[LFSR_W-2:0], fb}; acc <= {acc[OUT_W-2:0], fb}; bit counter increments.
REQ-019 On the FILL cycle with count=OUT_W-1: out_data <= {acc[OUT_W-2:0], fb}, count <= 0, next state PRESENT; oldest bit lands in the MSB.
REQ-020 In PRESENT, lfsr, acc and out_data SHALL hold; out_valid=1 until a cycle with out_ready=1.
REQ-021 Handshake (out_valid & out_ready) SHALL return to FILL next cycle; out_data stays stable until the next word; no word is lost or duplicated.
REQ-022 Throughput: one word per OUT_W+1 cycles with out_ready held high; first out_valid exactly OUT_W cycles after the first non-reset edge.
REQ-023 seed_load (not in reset) SHALL: lfsr <= seed (SEED_DEFAULT if seed==0), count <= 0, state <= FILL, out_valid <= 0; any partial or presented word is discarded.
REQ-024 seed_load coincident with handshake: seed_load wins; the presented word counts as consumed.
REQ-025 If the next-state LFSR value would be all-zero (FILL, mix_en=1), lfsr SHALL take SEED_DEFAULT instead and lockup SHALL pulse high for that cycle's update; the fb bit still enters acc.
REQ-026 lockup SHALL be 0 in every other cycle.
REQ-027 With mix_en=0, the sequence SHALL be fully deterministic from the seed.

Reset
REQ-028 rst SHALL take priority over seed_load and handshake.
REQ-029 On reset: lfsr=SEED_DEFAULT, acc=0, count=0, state=FILL, out_valid=0, out_data=0, lockup=0.
REQ-030 Reset asserted mid-word or in PRESENT SHALL discard the word; out_valid is 0 the following cycle.

Verification (LFSR_W=8, TAPS=8'hB8, SEED_DEFAULT=8'h01, OUT_W=4, mix_en=0 unless stated)
REQ-031 Reset then out_ready=1 -> out_valid first high 4 cycles after reset release; out_data=4'b0001, lfsr=8'h11; next word 4'b1100, lfsr=8'h1C.
REQ-032 out_ready=0 for 10 cycles after the first word -> out_valid and out_data=4'b0001 stable, lfsr stays 8'h11; release out_ready -> second word 4'b1100.
REQ-033 seed_load=1, seed=8'h00 mid-FILL -> lfsr=8'h01 next cycle, out_valid=0, first word 4'b0001 after 4 more cycles.
REQ-034 seed_load with handshake in the same cycle -> out_valid=0 next cycle, lfsr=seed, no second acceptance of the old word.
REQ-035 mix_en=1, seed 8'h80, mix chosen so fb=0 (next state 8'h00) -> lfsr=8'h01, lockup pulse exactly one cycle.
REQ-036 Scoreboard: 1000 words with random out_ready and mix_en=0 match a reference-model LFSR bit stream exactly; rst mid-word -> out_valid=0, sequence restarts from 8'h01.

Source files
------------

// File: rtl/lfsr_random_word_gen.sv
// Fibonacci LFSR that packs feedback bits into OUT_W-bit words and presents them
// on a valid/ready handshake, with optional entropy mixing and all-zero lock-up recovery.
module lfsr_random_word_gen #(
  parameter int                LFSR_W       = 16,
  parameter logic [LFSR_W-1:0] TAPS         = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = 16'h0001,
  parameter int                OUT_W        = 8,
  parameter int                MIX_W        = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              mix_en,
  input  logic [MIX_W-1:0]  mix,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic              lockup
);

  // state   | meaning
  // FILL    | shifting one feedback bit per cycle into the word accumulator
  // PRESENT | complete word held on out_data, waiting for out_ready

  localparam int CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  typedef enum logic {FILL, PRESENT} state_t;

  state_t            state;
  state_t            state_next;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_shift;
  logic [OUT_W-1:0]  acc;
  logic [OUT_W-1:0]  acc_shift;
  logic [CNT_W-1:0]  count;
  logic              fb;
  logic              word_done;
  logic              zero_next;

  assign fb         = (^(lfsr & TAPS)) ^ (mix_en & (^mix));
  assign lfsr_shift = {lfsr[LFSR_W-2:0], fb};
  assign word_done  = (state == FILL) && (count == CNT_W'(OUT_W - 1));
  // Without mixing a non-zero state cannot reach zero, so recovery only matters when mixing.
  assign zero_next  = mix_en && (lfsr_shift == '0);

  generate
    if (OUT_W > 1) begin : g_acc_wide
      assign acc_shift = {acc[OUT_W-2:0], fb};
    end else begin : g_acc_bit
      assign acc_shift = fb;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      FILL:    if (word_done) state_next = PRESENT;
      PRESENT: if (out_ready) state_next = FILL;
      default: state_next = FILL;
    endcase
    if (seed_load) begin
      state_next = FILL;
    end
  end

  always_comb begin
    out_valid = (state == PRESENT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr     <= SEED_DEFAULT;
      acc      <= '0;
      count    <= '0;
      out_data <= '0;
      lockup   <= 1'b0;
    end else begin
      lockup <= 1'b0;
      if (seed_load) begin
        lfsr  <= (seed == '0) ? SEED_DEFAULT : seed;
        acc   <= '0;
        count <= '0;
      end else if (state == FILL) begin
        lfsr   <= zero_next ? SEED_DEFAULT : lfsr_shift;
        lockup <= zero_next;
        acc    <= acc_shift;
        if (word_done) begin
          count    <= '0;
          out_data <= acc_shift;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lfsr_random_word_gen.sv
// Self-checking bench for lfsr_random_word_gen (8-bit LFSR, taps B8, 4-bit words)
// against an arithmetic bit-stream model.
module tb_lfsr_random_word_gen;

  localparam logic [7:0] TAPS_TB = 8'hB8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seed_load = 1'b0;
  logic [7:0]  seed = '0;
  logic        mix_en = 1'b0;
  logic [11:0] mix = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [3:0]  out_data;
  logic        lockup;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lfsr_random_word_gen #(
    .LFSR_W(8), .TAPS(8'hB8), .SEED_DEFAULT(8'h01), .OUT_W(4), .MIX_W(12)
  ) dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .mix_en(mix_en),
    .mix(mix), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .lockup(lockup)
  );

  // Reference: next state = (2*s + parity-of-tapped-bits) mod 256, zero replaced by 1.
  function automatic logic [7:0] model_next(input logic [7:0] s, input int mixpar,
                                            output int fb, output bit was_zero);
    int ones;
    int raw;
    ones = 0;
    for (int i = 0; i < 8; i++) if (s[i] && TAPS_TB[i]) ones++;
    fb = (ones + mixpar) % 2;
    raw = (int'(s) * 2 + fb) % 256;
    was_zero = (raw == 0);
    if (raw == 0) raw = 1;
    return raw[7:0];
  endfunction

  function automatic logic [3:0] model_word(input logic [7:0] s, output logic [7:0] s_out);
    int w;
    int fb;
    bit z;
    w = 0;
    s_out = s;
    for (int k = 0; k < 4; k++) begin
      s_out = model_next(s_out, 0, fb, z);
      w = w * 2 + fb;
    end
    return w[3:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; seed_load = 1'b0; mix_en = 1'b0; mix = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (out_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; seed_load = 1'b1; seed = 8'h77; out_ready = 1'b1;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 4'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", out_data); end
    checks++; if (lockup !== 1'b0) begin errors++; $display("FAIL reset_lockup got=%b exp=0", lockup); end
    checks++; if (dut.lfsr !== 8'h01) begin errors++; $display("FAIL reset_lfsr got=%h exp=01", dut.lfsr); end
    seed_load = 1'b0;
  endtask

  task automatic test_first_words();
    int n;
    do_reset();
    out_ready = 1'b1;
    wait_valid(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL first_latency got=%0d exp=4", n); end
    checks++; if (out_data !== 4'b0001) begin errors++; $display("FAIL first_word got=%b exp=0001", out_data); end
    checks++; if (dut.lfsr !== 8'h11) begin errors++; $display("FAIL first_lfsr got=%h exp=11", dut.lfsr); end
    wait_valid(n);
    checks++; if (n !== 5) begin errors++; $display("FAIL second_latency got=%0d exp=5", n); end
    checks++; if (out_data !== 4'b1100) begin errors++; $display("FAIL second_word got=%b exp=1100", out_data); end
    checks++; if (dut.lfsr !== 8'h1C) begin errors++; $display("FAIL second_lfsr got=%h exp=1C", dut.lfsr); end
  endtask

  task automatic test_stall();
    int n;
    do_reset();
    out_ready = 1'b0;
    wait_valid(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL stall_latency got=%0d exp=4", n); end
    repeat (10) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 4'b0001 || dut.lfsr !== 8'h11) begin
        errors++;
        $display("FAIL stall_hold got=%b/%b/%h exp=1/0001/11", out_valid, out_data, dut.lfsr);
      end
    end
    out_ready = 1'b1;
    wait_valid(n);
    checks++; if (n !== 5 || out_data !== 4'b1100) begin errors++; $display("FAIL stall_release got=%0d/%b exp=5/1100", n, out_data); end
  endtask

  task automatic test_seed_zero();
    int n;
    do_reset();
    out_ready = 1'b1;
    tick(); tick();
    seed_load = 1'b1; seed = 8'h00;
    tick();
    seed_load = 1'b0;
    checks++; if (dut.lfsr !== 8'h01) begin errors++; $display("FAIL seed_zero_lfsr got=%h exp=01", dut.lfsr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL seed_zero_valid got=%b exp=0", out_valid); end
    wait_valid(n);
    checks++; if (n !== 4 || out_data !== 4'b0001) begin errors++; $display("FAIL seed_zero_word got=%0d/%b exp=4/0001", n, out_data); end
  endtask

  task automatic test_seed_handshake();
    int n;
    logic [7:0] s_after;
    logic [3:0] exp_w;
    do_reset();
    out_ready = 1'b1;
    wait_valid(n);
    seed_load = 1'b1; seed = 8'h5A;
    tick();
    seed_load = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL seed_hs_valid got=%b exp=0", out_valid); end
    checks++; if (dut.lfsr !== 8'h5A) begin errors++; $display("FAIL seed_hs_lfsr got=%h exp=5A", dut.lfsr); end
    exp_w = model_word(8'h5A, s_after);
    wait_valid(n);
    checks++; if (n !== 4 || out_data !== exp_w) begin errors++; $display("FAIL seed_hs_word got=%0d/%b exp=4/%b", n, out_data, exp_w); end
    checks++; if (dut.lfsr !== s_after) begin errors++; $display("FAIL seed_hs_lfsr2 got=%h exp=%h", dut.lfsr, s_after); end
  endtask

  task automatic test_lockup();
    logic [7:0] exp_s;
    int fb;
    bit z;
    do_reset();
    seed_load = 1'b1; seed = 8'h80;
    tick();
    seed_load = 1'b0;
    checks++; if (lockup !== 1'b0) begin errors++; $display("FAIL lockup_pre got=%b exp=0", lockup); end
    mix_en = 1'b1; mix = 12'h001;
    exp_s = model_next(8'h80, 1, fb, z);
    tick();
    mix_en = 1'b0;
    checks++; if (lockup !== z) begin errors++; $display("FAIL lockup_pulse got=%b exp=%b", lockup, z); end
    checks++; if (dut.lfsr !== exp_s) begin errors++; $display("FAIL lockup_lfsr got=%h exp=%h", dut.lfsr, exp_s); end
    tick();
    checks++; if (lockup !== 1'b0) begin errors++; $display("FAIL lockup_clear got=%b exp=0", lockup); end
  endtask

  task automatic test_scoreboard();
    logic [7:0] m_s;
    logic [7:0] m_next;
    logic [3:0] exp_w;
    logic [3:0] held_data;
    bit held;
    int words;
    do_reset();
    m_s = 8'h01;
    held = 1'b0;
    held_data = '0;
    words = 0;
    for (int cyc = 0; cyc < 30000 && words < 1000; cyc++) begin
      tick();
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held_data) begin
          errors++;
          $display("FAIL sb_hold got=%b/%b exp=1/%b", out_valid, out_data, held_data);
        end
      end
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        exp_w = model_word(m_s, m_next);
        m_s = m_next;
        checks++;
        if (out_data !== exp_w || dut.lfsr !== m_s) begin
          errors++;
          $display("FAIL sb_word%0d got=%b/%h exp=%b/%h", words, out_data, dut.lfsr, exp_w, m_s);
        end
        words++;
      end
      held = out_valid && !out_ready;
      held_data = out_data;
    end
    checks++; if (words !== 1000) begin errors++; $display("FAIL sb_count got=%0d exp=1000", words); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    out_ready = 1'b1;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || dut.lfsr !== 8'h01) begin errors++; $display("FAIL rst_mid got=%b/%h exp=0/01", out_valid, dut.lfsr); end
    out_ready = 1'b0;
    wait_valid(n);
    checks++; if (n !== 4 || out_data !== 4'b0001) begin errors++; $display("FAIL rst_mid_word got=%0d/%b exp=4/0001", n, out_data); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || dut.lfsr !== 8'h01) begin errors++; $display("FAIL rst_present got=%b/%h exp=0/01", out_valid, dut.lfsr); end
  endtask

  initial begin
    test_reset();
    test_first_words();
    test_stall();
    test_seed_zero();
    test_seed_handshake();
    test_lockup();
    test_scoreboard();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
